// File: rtl/defuzz_div.sv
// Defuzzification back end: sequential restoring divider computing g = S_wg / S_w as Q1.15 and percent.
// Optional build macro DEFUZZ_ROUND_EN selects a round-half-up quotient instead of a truncating one.
module defuzz_div #(
  parameter int          SW_W      = 24,
  parameter int          SWG_W     = 32,
  parameter int          QW        = 16,
  parameter logic [15:0] DEFAULT_G = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SW_W-1:0]  S_w,
  input  logic [SWG_W-1:0] S_wg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      g_q15,
  output logic [6:0]       g_pct,
  output logic             no_rule,
  output logic             sat
);

  localparam int DW    = SWG_W + 1;
  localparam int HW    = DW - QW;
  localparam int CW    = ((HW > SW_W) ? HW : SW_W) + 1;
  localparam int CNT_W = $clog2(QW);

  typedef enum logic [1:0] {IDLE, DIV, SCALE, DONE} state_t;

  state_t            state, state_next;
  logic [SW_W-1:0]   divisor;
  logic [SW_W:0]     rem;
  logic [QW-1:0]     dlo;
  logic [QW-1:0]     quo;
  logic [CNT_W-1:0]  cnt;
  logic              zero;
  logic              ovf;

  logic [SW_W-1:0]   bias;
  logic [DW-1:0]     dividend;
  logic [CW-1:0]     hi_ext;
  logic [CW-1:0]     sw_ext;
  logic              ovf_in;
  logic [SW_W+1:0]   trial;
  logic [SW_W+1:0]   diff;
  logic              ge;
  logic [15:0]       g_next;
  logic              sat_next;
  logic [23:0]       prod;
  logic [23:0]       pfull;
  logic [6:0]        pct_next;

`ifdef DEFUZZ_ROUND_EN
  assign bias = S_w >> 1;
`else
  assign bias = '0;
`endif

  // Quotient exceeds QW bits exactly when the dividend's upper part is already >= divisor,
  // so the upper part seeds the remainder and only the low QW bits are iterated.
  assign dividend = {1'b0, S_wg} + DW'(bias);
  assign hi_ext   = CW'(dividend[DW-1:QW]);
  assign sw_ext   = CW'(S_w);
  assign ovf_in   = (S_w != '0) && (hi_ext >= sw_ext);

  assign trial = {rem, dlo[QW-1]};
  assign diff  = trial - (SW_W+2)'(divisor);
  assign ge    = trial >= (SW_W+2)'(divisor);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = (S_w == '0) ? SCALE : DIV;
      DIV:     if (cnt == '0) state_next = SCALE;
      SCALE:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    g_next   = DEFAULT_G;
    sat_next = 1'b0;
    if (!zero) begin
      if (ovf || (|quo[QW-1:15])) begin
        g_next   = 16'h7FFF;
        sat_next = 1'b1;
      end else begin
        g_next = {1'b0, quo[14:0]};
      end
    end
    prod     = {8'd0, g_next} * 24'd100 + 24'd16384;
    pfull    = prod >> 15;
    pct_next = (pfull > 24'd100) ? 7'd100 : pfull[6:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divisor <= '0;
      rem     <= '0;
      dlo     <= '0;
      quo     <= '0;
      cnt     <= '0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      g_q15   <= '0;
      g_pct   <= '0;
      no_rule <= 1'b0;
      sat     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          divisor <= S_w;
          zero    <= (S_w == '0);
          ovf     <= ovf_in;
          rem     <= (SW_W+1)'(hi_ext);
          dlo     <= dividend[QW-1:0];
          quo     <= '0;
          cnt     <= CNT_W'(QW - 1);
        end
        DIV: begin
          rem <= (SW_W+1)'(ge ? diff : trial);
          dlo <= {dlo[QW-2:0], 1'b0};
          quo <= {quo[QW-2:0], ge};
          cnt <= cnt - 1'b1;
        end
        SCALE: begin
          g_q15   <= g_next;
          g_pct   <= pct_next;
          no_rule <= zero;
          sat     <= sat_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_defuzz_div.sv
// Self-checking bench for defuzz_div: directed corner cases plus randomized transactions
// compared against an arithmetic reference model.
module tb_defuzz_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] S_w;
  logic [31:0] S_wg;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] g_q15;
  logic [6:0]  g_pct;
  logic        no_rule;
  logic        sat;

  int tests = 0;
  int fails = 0;

  defuzz_div dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .S_w(S_w), .S_wg(S_wg),
    .out_valid(out_valid), .out_ready(out_ready),
    .g_q15(g_q15), .g_pct(g_pct), .no_rule(no_rule), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] g;
    logic [6:0]  pct;
    logic        nr;
    logic        st;
  } res_t;

  function automatic res_t model(input logic [23:0] sw, input logic [31:0] swg);
    res_t   r;
    longint num, q, p;
    r.nr = 1'b0;
    r.st = 1'b0;
    if (sw == 0) begin
      r.g  = 16'h0000;
      r.nr = 1'b1;
    end else begin
      num = longint'(swg);
`ifdef DEFUZZ_ROUND_EN
      num = num + longint'(sw) / 2;
`endif
      q = num / longint'(sw);
      if (q > 32767) begin
        r.g  = 16'h7FFF;
        r.st = 1'b1;
      end else begin
        r.g = q[15:0];
      end
    end
    p = (longint'(r.g) * 100 + 16384) / 32768;
    if (p > 100) p = 100;
    r.pct = p[6:0];
    return r;
  endfunction

  task automatic run_txn(input logic [23:0] sw, input logic [31:0] swg, input int stall);
    res_t e;
    int   lat;
    e = model(sw, swg);
    @(posedge clk); #1;
    check("in_ready_idle", in_ready, 1'b1);
    S_w = sw; S_wg = swg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, (sw == 0) ? 2 : 18);
    check("g_q15", g_q15, e.g);
    check("g_pct", g_pct, e.pct);
    check("no_rule", no_rule, e.nr);
    check("sat", sat, e.st);
    for (int i = 0; i < stall; i++) begin
      S_w = 24'h000003; S_wg = 32'h00000005; in_valid = 1'b1;
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1'b1);
      check("stall_ready", in_ready, 1'b0);
      check("stall_g", g_q15, e.g);
      check("stall_pct", g_pct, e.pct);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("consumed_valid", out_valid, 1'b0);
    check("consumed_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic [23:0] sw;
    logic [31:0] swg;
    longint      t;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; S_w = '0; S_wg = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_g", g_q15, 16'h0000);
    check("rst_pct", g_pct, 7'd0);
    check("rst_no_rule", no_rule, 1'b0);
    check("rst_sat", sat, 1'b0);

    run_txn(24'h007FFF, 32'h1FFF_C000, 0);
    run_txn(24'h000000, 32'h0000_1234, 0);
    run_txn(24'h000001, 32'h0001_0000, 0);
    run_txn(24'h000003, 32'h0000_0005, 0);
    run_txn(24'h000400, 32'h0000_0000, 10);
    run_txn(24'hFFFFFF, 32'hFFFF_FFFF, 0);

    // Reset in the middle of a division aborts it.
    @(posedge clk); #1;
    S_w = 24'h000123; S_wg = 32'h0012_3456; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_valid", out_valid, 1'b0);
    check("abort_ready", in_ready, 1'b1);
    repeat (25) begin
      @(posedge clk); #1;
      check("abort_silent", out_valid, 1'b0);
    end
    run_txn(24'h000123, 32'h0012_3456, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom % 4)
        0: begin sw = '0; swg = $urandom; end
        1: begin sw = 24'($urandom_range(1, 255)); swg = $urandom; end
        2: begin
          sw  = 24'($urandom_range(1, 32'h1FFFF));
          t   = longint'(sw) * longint'($urandom_range(0, 32767)) + longint'($urandom % sw);
          swg = t[31:0];
        end
        default: begin sw = 24'($urandom); swg = $urandom; end
      endcase
      run_txn(sw, swg, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
